// File: rtl/nlc_out_collect.sv
// Output collector for the NLC datapath: converts binary32 results to 21-bit
// fixed point, stores them per channel and signals when a frame is complete.
module nlc_out_collect #(
  parameter int NCH  = 16,
  parameter int IDXW = 4,
  parameter int XW   = 21,
  parameter int FW   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              srdyi,
  input  logic [IDXW-1:0]   ch_idx,
  input  logic [FW-1:0]     result_f,
  output logic [NCH*XW-1:0] x_lin_bus,
  output logic [NCH-1:0]    sat_flags,
  output logic              dup_err,
  output logic              srdyo
);

  localparam logic [XW-1:0] POS_MAX = {1'b0, {(XW-1){1'b1}}};
  localparam logic [XW-1:0] NEG_MAX = {1'b1, {(XW-1){1'b0}}};

  // ---------------- stage 0: decode and align ----------------
  logic [7:0]  exp_w;
  logic [22:0] man_w;
  logic [23:0] sig_w;
  logic [7:0]  sh_w;
  logic [23:0] shifted_w;
  logic        nan_d, sat_d;
  logic [21:0] half_d;

  assign exp_w = result_f[30:23];
  assign man_w = result_f[22:0];
  assign sig_w = {1'b1, man_w};
  assign sh_w  = 8'd149 - exp_w;
  assign shifted_w = sig_w >> sh_w;

  // half_d holds floor(|x| * 2): integer magnitude plus the round bit in bit 0.
  always_comb begin
    nan_d  = 1'b0;
    sat_d  = 1'b0;
    half_d = '0;
    if (exp_w == 8'd255) begin
      nan_d = (man_w != '0);
      sat_d = (man_w == '0);
    end else if (exp_w >= 8'd148) begin
      sat_d = 1'b1;
    end else if (exp_w >= 8'd126) begin
      half_d = shifted_w[21:0];
    end
  end

  logic            v1_q;
  logic [IDXW-1:0] ch1_q;
  logic            sign1_q, nan1_q, sat1_q;
  logic [21:0]     half1_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      v1_q    <= 1'b0;
      ch1_q   <= '0;
      sign1_q <= 1'b0;
      nan1_q  <= 1'b0;
      sat1_q  <= 1'b0;
      half1_q <= '0;
    end else begin
      v1_q    <= srdyi;
      ch1_q   <= ch_idx;
      sign1_q <= result_f[31];
      nan1_q  <= nan_d;
      sat1_q  <= sat_d;
      half1_q <= half_d;
    end
  end

  // ---------------- stage 1: round, sign, saturate ----------------
  logic [22:0]   mag_sum;
  logic [21:0]   mag_w;
  logic [XW-1:0] val_d;
  logic          flag_d;

  assign mag_sum = {1'b0, half1_q} + 23'd1;
  assign mag_w   = mag_sum[22:1];

  always_comb begin
    val_d  = '0;
    flag_d = 1'b0;
    if (nan1_q) begin
      flag_d = 1'b1;
    end else if (sat1_q) begin
      val_d  = sign1_q ? NEG_MAX : POS_MAX;
      flag_d = 1'b1;
    end else if (!sign1_q) begin
      if (mag_w > 22'd1048575) begin
        val_d  = POS_MAX;
        flag_d = 1'b1;
      end else begin
        val_d = mag_w[XW-1:0];
      end
    end else begin
      if (mag_w > 22'd1048576) begin
        val_d  = NEG_MAX;
        flag_d = 1'b1;
      end else begin
        val_d = XW'(-mag_w[XW-1:0]);
      end
    end
  end

  // ---------------- bank and frame tracking ----------------
  logic [XW-1:0]  bank_q [NCH];
  logic [NCH-1:0] sat_q;
  logic [NCH-1:0] mask_q, mask_set;
  logic           dup_q, srdyo_q;

  assign mask_set = mask_q | (NCH'(1) << ch1_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NCH; i++) bank_q[i] <= '0;
      sat_q   <= '0;
      mask_q  <= '0;
      dup_q   <= 1'b0;
      srdyo_q <= 1'b0;
    end else begin
      srdyo_q <= 1'b0;
      if (v1_q) begin
        bank_q[ch1_q] <= val_d;
        sat_q[ch1_q]  <= flag_d;
        if (mask_q[ch1_q]) dup_q <= 1'b1;
        if (&mask_set) begin
          mask_q  <= '0;
          srdyo_q <= 1'b1;
        end else begin
          mask_q <= mask_set;
        end
      end
    end
  end

  for (genvar gi = 0; gi < NCH; gi++) begin : g_bus
    assign x_lin_bus[gi*XW +: XW] = bank_q[gi];
  end

  assign sat_flags = sat_q;
  assign dup_err   = dup_q;
  assign srdyo     = srdyo_q;

endmodule

// File: tb/tb_nlc_out_collect.sv
// Directed bench for nlc_out_collect: conversion, saturation, frame pulse,
// duplicate detection and mid-frame reset, all against hand-computed values.
module tb_nlc_out_collect;

  localparam int NCH = 16;
  localparam int XW  = 21;

  logic              clk = 1'b0;
  logic              reset;
  logic              srdyi;
  logic [3:0]        ch_idx;
  logic [31:0]       result_f;
  logic [NCH*XW-1:0] x_lin_bus;
  logic [NCH-1:0]    sat_flags;
  logic              dup_err;
  logic              srdyo;

  int n_checks = 0;
  int n_pass   = 0;
  int pulse_cnt = 0;
  int pc0;

  logic [31:0] frame_f [16] = '{
    32'h00000000, 32'h41200000, 32'h41A00000, 32'h41F00000,
    32'h42200000, 32'h42480000, 32'h42700000, 32'h428C0000,
    32'h42A00000, 32'h42B40000, 32'h42C80000, 32'h42DC0000,
    32'h42F00000, 32'h43020000, 32'h430C0000, 32'h43160000};

  nlc_out_collect dut (
    .clk       (clk),
    .reset     (reset),
    .srdyi     (srdyi),
    .ch_idx    (ch_idx),
    .result_f  (result_f),
    .x_lin_bus (x_lin_bus),
    .sat_flags (sat_flags),
    .dup_err   (dup_err),
    .srdyo     (srdyo)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (srdyo) pulse_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [31:0] xl(input int n);
    return 32'(x_lin_bus[n*XW +: XW]);
  endfunction

  task automatic put(input int ch, input logic [31:0] f);
    srdyi = 1'b1; ch_idx = 4'(ch); result_f = f;
    @(negedge clk);
    $display("put ch%0d f=0x%08h", ch, f);
  endtask

  task automatic idle();
    srdyi = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1; srdyi = 1'b1; ch_idx = 4'd0; result_f = 32'h3F800000;
    @(negedge clk);
    reset = 1'b0; srdyi = 1'b0;
  endtask

  initial begin
    reset = 1'b0; srdyi = 1'b0; ch_idx = '0; result_f = '0;
    @(negedge clk);
    do_reset();
    check("rst_bus",   32'(|x_lin_bus), 32'd0);
    check("rst_flags", 32'(sat_flags), 32'd0);
    check("rst_dup",   32'(dup_err), 32'd0);
    check("rst_srdyo", 32'(srdyo), 32'd0);

    // Basic conversion: two-edge latency
    pc0 = pulse_cnt;
    put(0, 32'h3F800000);
    check("lat_not_yet", xl(0), 32'd0);
    idle();
    check("x0_one", xl(0), 32'd1);
    check("f0", 32'(sat_flags[0]), 32'd0);

    // Rounding and special values, back-to-back
    put(1, 32'h40200000);
    put(2, 32'hC0200000);
    put(3, 32'h3EFAE148);
    put(4, 32'h3F000000);
    put(5, 32'h4A000000);
    put(6, 32'hC9800000);
    put(7, 32'h7F800000);
    put(8, 32'h7FC00000);
    put(9, 32'h00000001);
    idle(); idle();
    check("x1_2p5",   xl(1), 32'd3);
    check("x2_m2p5",  xl(2), 32'h1FFFFD);
    check("x3_0p49",  xl(3), 32'd0);
    check("x4_0p5",   xl(4), 32'd1);
    check("x5_2p21",  xl(5), 32'h0FFFFF);
    check("x6_neg",   xl(6), 32'h100000);
    check("x7_inf",   xl(7), 32'h0FFFFF);
    check("x8_nan",   xl(8), 32'd0);
    check("x9_den",   xl(9), 32'd0);
    check("flags_1_9", 32'(sat_flags[9:1]), 32'b0_1101_0000);
    check("no_pulse_partial", 32'(pulse_cnt - pc0), 32'd0);
    check("no_dup_partial", 32'(dup_err), 32'd0);

    // Full frame of n*10.0
    do_reset();
    pc0 = pulse_cnt;
    for (int n = 0; n < 16; n++) put(n, frame_f[n]);
    check("srdyo_before_write", 32'(srdyo), 32'd0);
    put(5, frame_f[5]);
    check("srdyo_pulse", 32'(srdyo), 32'd1);
    idle();
    check("srdyo_one_cycle", 32'(srdyo), 32'd0);
    idle(); idle();
    check("frame_pulses", 32'(pulse_cnt - pc0), 32'd1);
    check("frame_no_dup", 32'(dup_err), 32'd0);
    for (int n = 0; n < 16; n++) check($sformatf("frame_x%0d", n), xl(n), 32'(n * 10));
    check("frame_flags", 32'(sat_flags), 32'd0);

    // Duplicate within a frame
    do_reset();
    pc0 = pulse_cnt;
    put(3, 32'h3F800000);
    idle();
    check("dup_first", 32'(dup_err), 32'd0);
    put(3, 32'h40E00000);
    idle();
    check("dup_second", 32'(dup_err), 32'd1);
    check("dup_x3", xl(3), 32'd7);
    for (int n = 0; n < 15; n++) if (n != 3) put(n, 32'h3F800000);
    idle(); idle();
    check("dup_no_early_pulse", 32'(pulse_cnt - pc0), 32'd0);
    put(15, 32'h3F800000);
    idle(); idle();
    check("dup_pulse", 32'(pulse_cnt - pc0), 32'd1);
    check("dup_sticky", 32'(dup_err), 32'd1);
    check("dup_x3_kept", xl(3), 32'd7);

    // Reset mid-frame with srdyi high
    for (int n = 0; n < 8; n++) put(n, frame_f[n + 1]);
    reset = 1'b1; srdyi = 1'b1; ch_idx = 4'd8; result_f = 32'h41200000;
    @(negedge clk);
    reset = 1'b0; srdyi = 1'b0;
    idle(); idle();
    check("mid_bus",   32'(|x_lin_bus), 32'd0);
    check("mid_flags", 32'(sat_flags), 32'd0);
    check("mid_dup",   32'(dup_err), 32'd0);
    pc0 = pulse_cnt;
    for (int n = 8; n < 16; n++) put(n, 32'h3F800000);
    idle(); idle();
    check("mid_no_pulse", 32'(pulse_cnt - pc0), 32'd0);
    for (int n = 0; n < 8; n++) put(n, 32'h3F800000);
    idle(); idle();
    check("mid_pulse", 32'(pulse_cnt - pc0), 32'd1);
    check("mid_no_dup", 32'(dup_err), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
